// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide engine: op encodings,
// FSM states and the start-to-done latency helper.
package muldiv_pkg;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } md_state_t;

   // Cycle offset from the accepting edge to the DONE cycle of the iterative path.
   function automatic int md_latency(input int width, input int step);
      return (width / step) + 32'sd1;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the engine: STEP bits of restoring
// shift-subtract (divide, MSB first) or shift-add (multiply, LSB first).
module muldiv_step #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic             div_i,
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] shreg_i,
   input  logic [WIDTH-1:0] opnd_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] shreg_o
);

   logic [WIDTH-1:0] rem_v;
   logic [WIDTH-1:0] sh_v;
   logic [WIDTH:0]   shifted_v;
   logic [WIDTH:0]   trial_v;
   logic [WIDTH:0]   sum_v;

   // Unrolled iterations; the partial remainder is widened to WIDTH+1 for the trial subtract.
   always_comb begin
      rem_v     = rem_i;
      sh_v      = shreg_i;
      shifted_v = '0;
      trial_v   = '0;
      sum_v     = '0;
      for (int i = 0; i < STEP; i++) begin
         if (div_i) begin
            shifted_v = {rem_v, sh_v[WIDTH-1]};
            trial_v   = shifted_v - {1'b0, opnd_i};
            if (trial_v[WIDTH]) begin
               rem_v = shifted_v[WIDTH-1:0];
               sh_v  = {sh_v[WIDTH-2:0], 1'b0};
            end else begin
               rem_v = trial_v[WIDTH-1:0];
               sh_v  = {sh_v[WIDTH-2:0], 1'b1};
            end
         end else begin
            sum_v = {1'b0, rem_v} + {1'b0, opnd_i & {WIDTH{sh_v[0]}}};
            rem_v = sum_v[WIDTH:1];
            sh_v  = {sum_v[0], sh_v[WIDTH-1:1]};
         end
      end
      rem_o   = rem_v;
      shreg_o = sh_v;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine with start/done handshake and annul.
// Define MULDIV_FAST_MUL_EN for a single-cycle registered array multiply.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             annul,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int NITER = md_latency(WIDTH, STEP) - 1;
   localparam int CW    = $clog2(NITER + 1);
   localparam logic [CW-1:0] LAST = CW'(NITER - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   md_state_t state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] rem_q, rem_d, sh_q, sh_d, opnd_q, opnd_d, araw_q, araw_d;
   logic             div_q, div_d, neg_q, neg_d, aneg_q, aneg_d, bz_q, bz_d;

   logic             cap_sgn, cap_aneg, cap_bneg;
   logic [WIDTH-1:0] mag_a, mag_b, rem_s, sh_s, fix_hi, fix_lo;
   logic [2*WIDTH-1:0] prod_s;

   // Signed ops run on magnitudes; the original signs are kept for the fix-up.
   assign cap_sgn  = ~op[0];
   assign cap_aneg = cap_sgn & a[WIDTH-1];
   assign cap_bneg = cap_sgn & b[WIDTH-1];
   assign mag_a    = cap_aneg ? -a : a;
   assign mag_b    = cap_bneg ? -b : b;

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod;
   assign fast_prod = {{WIDTH{cap_aneg}}, a} * {{WIDTH{cap_bneg}}, b};
`endif

   muldiv_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
      .div_i   (div_q),
      .rem_i   (rem_q),
      .shreg_i (sh_q),
      .opnd_i  (opnd_q),
      .rem_o   (rem_s),
      .shreg_o (sh_s)
   );

   // Sign fix-up of the final iteration, with the divide-by-zero override.
   always_comb begin
      fix_hi = '0;
      fix_lo = '0;
      prod_s = {rem_s, sh_s};
      if (div_q) begin
         if (bz_q) begin
            fix_lo = '1;
            fix_hi = araw_q;
         end else begin
            fix_lo = neg_q ? -sh_s : sh_s;
            fix_hi = aneg_q ? -rem_s : rem_s;
         end
      end else begin
         {fix_hi, fix_lo} = neg_q ? -prod_s : prod_s;
      end
   end

   // Next-state, capture and result-commit logic.
   always_comb begin
      state_d = state_q;  cnt_d  = cnt_q;   busy_d = busy_q;  done_d = 1'b0;
      hi_d    = hi_q;     lo_d   = lo_q;    dz_d   = dz_q;
      rem_d   = rem_q;    sh_d   = sh_q;    opnd_d = opnd_q;  araw_d = araw_q;
      div_d   = div_q;    neg_d  = neg_q;   aneg_d = aneg_q;  bz_d   = bz_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !annul) begin
               busy_d  = 1'b1;
               cnt_d   = '0;
               rem_d   = '0;
               sh_d    = op[1] ? mag_a : mag_b;
               opnd_d  = op[1] ? mag_b : mag_a;
               div_d   = op[1];
               neg_d   = cap_aneg ^ cap_bneg;
               aneg_d  = cap_aneg;
               bz_d    = (b == '0);
               araw_d  = a;
               state_d = ST_RUN;
`ifdef MULDIV_FAST_MUL_EN
               if (!op[1]) begin
                  {hi_d, lo_d} = fast_prod;
                  dz_d    = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (annul) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else if (cnt_q == LAST) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               done_d  = 1'b1;
               hi_d    = fix_hi;
               lo_d    = fix_lo;
               dz_d    = div_q & bz_q;
            end else begin
               cnt_d = cnt_q + ONE;
               rem_d = rem_s;
               sh_d  = sh_s;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;  cnt_q  <= '0;    busy_q <= 1'b0;  done_q <= 1'b0;
         hi_q    <= '0;       lo_q   <= '0;    dz_q   <= 1'b0;
         rem_q   <= '0;       sh_q   <= '0;    opnd_q <= '0;    araw_q <= '0;
         div_q   <= 1'b0;     neg_q  <= 1'b0;  aneg_q <= 1'b0;  bz_q   <= 1'b0;
      end else begin
         state_q <= state_d;  cnt_q  <= cnt_d; busy_q <= busy_d; done_q <= done_d;
         hi_q    <= hi_d;     lo_q   <= lo_d;  dz_q   <= dz_d;
         rem_q   <= rem_d;    sh_q   <= sh_d;  opnd_q <= opnd_d; araw_q <= araw_d;
         div_q   <= div_d;    neg_q  <= neg_d; aneg_q <= aneg_d; bz_q   <= bz_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: STEP=1 and STEP=2 instances, WIDTH=32.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_r = 1'b0;
   logic        sel = 1'b0;
   logic [1:0]  op_r = 2'b00;
   logic [31:0] a_r = 32'd0;
   logic [31:0] b_r = 32'd0;
   logic        annul_r = 1'b0;

   logic        busy1, done1, dz1, busy2, done2, dz2;
   logic [31:0] hi1, lo1, hi2, lo2;
   logic        busy_m, done_m, dz_m;
   logic [31:0] hi_m, lo_m;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32), .STEP(1)) dut1 (
      .clk(clk), .rst(rst), .start(start_r & ~sel), .op(op_r), .a(a_r), .b(b_r),
      .annul(annul_r), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1), .div_zero(dz1)
   );

   muldiv_unit #(.WIDTH(32), .STEP(2)) dut2 (
      .clk(clk), .rst(rst), .start(start_r & sel), .op(op_r), .a(a_r), .b(b_r),
      .annul(annul_r), .busy(busy2), .done(done2), .hi(hi2), .lo(lo2), .div_zero(dz2)
   );

   assign busy_m = sel ? busy2 : busy1;
   assign done_m = sel ? done2 : done1;
   assign dz_m   = sel ? dz2 : dz1;
   assign hi_m   = sel ? hi2 : hi1;
   assign lo_m   = sel ? lo2 : lo1;

   function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] h, output logic [31:0] l, output logic z);
      logic signed [63:0] sx, sy, p;
      sx = $signed(x);
      sy = $signed(y);
      z = 1'b0;
      h = 32'd0;
      l = 32'd0;
      case (o)
         MD_MULT:  begin p = sx * sy; {h, l} = p; end
         MD_MULTU: begin {h, l} = {32'd0, x} * {32'd0, y}; end
         MD_DIV: begin
            if (y == 32'd0) begin l = 32'hFFFFFFFF; h = x; z = 1'b1; end
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin l = x; h = 32'd0; end
            else begin l = $signed(x) / $signed(y); h = $signed(x) % $signed(y); end
         end
         default: begin
            if (y == 32'd0) begin l = 32'hFFFFFFFF; h = x; z = 1'b1; end
            else begin l = x / y; h = x % y; end
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] o, input int step);
`ifdef MULDIV_FAST_MUL_EN
      if (!o[1]) return 1;
`endif
      return md_latency(32, step);
   endfunction

   task automatic run_op(input logic s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                         input string nm, input int pulse_at, input bit no_wait);
      exp_t e;
      int   n;
      bit   seen, busy_ok;
      if (!no_wait) @(negedge clk);
      sel = s; op_r = o; a_r = x; b_r = y; start_r = 1'b1;
      e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = exp_lat(o, s ? 2 : 1);
      sb.push_back(e);
      @(posedge clk);
      #1;
      start_r = 1'b0;
      op_r = 2'($urandom); a_r = $urandom; b_r = $urandom;
      n = 0; seen = 1'b0; busy_ok = 1'b1;
      while (!seen && n < 100) begin
         @(negedge clk);
         n++;
         start_r = (n == pulse_at);
         if (busy_m !== 1'b1) busy_ok = 1'b0;
         if (done_m === 1'b1) seen = 1'b1;
      end
      start_r = 1'b0;
      e = sb.pop_front();
      total++;
      if (!busy_ok) begin bad++; $display("FAIL %s busy: dropped before done, want high through done", nm); end
      total++;
      if (!seen) begin
         bad++; $display("FAIL %s done: none within 100 cycles, want cycle %0d", nm, e.lat);
      end else begin
         total++;
         if (n !== e.lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", nm, n, e.lat); end
         if (hi_m !== e.hi) begin bad++; $display("FAIL %s hi: got %h want %h", nm, hi_m, e.hi); end
         total++;
         if (lo_m !== e.lo) begin bad++; $display("FAIL %s lo: got %h want %h", nm, lo_m, e.lo); end
         total++;
         if (dz_m !== e.dz) begin bad++; $display("FAIL %s div_zero: got %b want %b", nm, dz_m, e.dz); end
      end
      @(negedge clk);
      total++;
      if ({busy_m, done_m} !== 2'b00) begin
         bad++; $display("FAIL %s idle: busy,done got %b want 00", nm, {busy_m, done_m});
      end
   endtask

   task automatic run_model(input logic s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            input string nm, input bit no_wait);
      logic [31:0] h, l;
      logic z;
      model(o, x, y, h, l, z);
      run_op(s, o, x, y, h, l, z, nm, 0, no_wait);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({busy1, done1, hi1, lo1, dz1} !== 67'd0) begin
         bad++; $display("FAIL reset1: got %b/%b/%h/%h/%b want all zero", busy1, done1, hi1, lo1, dz1);
      end
      total++;
      if ({busy2, done2, hi2, lo2, dz2} !== 67'd0) begin
         bad++; $display("FAIL reset2: got %b/%b/%h/%h/%b want all zero", busy2, done2, hi2, lo2, dz2);
      end
      rst = 1'b0;
   endtask

   task automatic test_div();
      run_op(1'b0, MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_100_7", 0, 1'b0);
      run_op(1'b0, MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2", 0, 1'b0);
      run_op(1'b0, MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, "div_min_m1", 0, 1'b0);
      run_model(1'b0, MD_DIV, 32'd1000, 32'hFFFFFFF9, "div_pos_neg", 1'b0);
      for (int i = 0; i < 3; i++) run_model(1'b0, {1'b1, 1'($urandom)}, $urandom, $urandom_range(1, 70000), "div_rand", 1'b0);
   endtask

   task automatic test_div_zero();
      run_op(1'b0, MD_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, "divu_zero", 0, 1'b0);
      run_op(1'b0, MD_DIV, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b1, "div_neg_zero", 0, 1'b0);
      run_op(1'b0, MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_dz_clear", 0, 1'b0);
   endtask

   task automatic test_mul();
      run_op(1'b0, MD_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, "mult_m3_5", 0, 1'b0);
      run_op(1'b0, MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 1'b0, "multu_max", 0, 1'b0);
      for (int i = 0; i < 3; i++) run_model(1'b0, {1'b0, 1'($urandom)}, $urandom, $urandom, "mul_rand", 1'b0);
   endtask

   task automatic test_annul();
      bit saw_done;
      run_op(1'b0, MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "annul_pre", 0, 1'b0);
      @(negedge clk);
      sel = 1'b0; op_r = MD_DIVU; a_r = 32'd1000; b_r = 32'd3; start_r = 1'b1;
      @(posedge clk);
      #1;
      start_r = 1'b0;
      saw_done = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (done1 === 1'b1) saw_done = 1'b1;
      end
      annul_r = 1'b1;
      @(posedge clk);
      #1;
      annul_r = 1'b0;
      @(negedge clk);
      total++;
      if ({saw_done, busy1, done1} !== 3'b000) begin
         bad++; $display("FAIL annul ctl: saw_done,busy,done got %b want 000", {saw_done, busy1, done1});
      end
      total++;
      if ({hi1, lo1} !== {32'd2, 32'd14}) begin
         bad++; $display("FAIL annul keep: got %h/%h want 00000002/0000000e", hi1, lo1);
      end
      run_op(1'b0, MD_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, "annul_restart", 0, 1'b1);
   endtask

   task automatic test_start_ignored();
      bit quiet;
      run_op(1'b0, MD_DIVU, 32'd200, 32'd9, 32'd2, 32'd22, 1'b0, "start_mid_run", 5, 1'b0);
      quiet = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (busy1 !== 1'b0 || done1 !== 1'b0) quiet = 1'b0;
      end
      total++;
      if (!quiet) begin bad++; $display("FAIL start_queued: got activity after done, want idle"); end
   endtask

   task automatic test_idle_annul();
      @(negedge clk);
      sel = 1'b0; op_r = MD_DIVU; a_r = 32'd5; b_r = 32'd1; start_r = 1'b1; annul_r = 1'b1;
      @(posedge clk);
      #1;
      start_r = 1'b0; annul_r = 1'b0;
      @(negedge clk);
      total++;
      if ({busy1, done1} !== 2'b00) begin
         bad++; $display("FAIL idle_annul: busy,done got %b want 00", {busy1, done1});
      end
   endtask

   task automatic test_back_to_back();
      run_model(1'b0, MD_DIVU, 32'd77, 32'd5, "b2b_0", 1'b0);
      run_model(1'b0, MD_MULT, 32'hFFFF0000, 32'd3, "b2b_1", 1'b1);
      run_model(1'b0, MD_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, "b2b_2", 1'b1);
   endtask

   task automatic test_step2();
      run_op(1'b1, MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "s2_divu", 0, 1'b0);
      run_model(1'b1, MD_DIV, 32'hFFFFFFF9, 32'd2, "s2_div", 1'b0);
      run_model(1'b1, MD_MULT, 32'hFFFFFFFD, 32'd5, "s2_mult", 1'b0);
      @(negedge clk);
      sel = 1'b1; op_r = MD_DIVU; a_r = 32'd50; b_r = 32'd3; start_r = 1'b1;
      @(posedge clk);
      #1;
      start_r = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({busy2, done2, hi2, lo2, dz2} !== 67'd0) begin
         bad++; $display("FAIL s2_rst_mid_run: got %b/%b/%h/%h/%b want all zero", busy2, done2, hi2, lo2, dz2);
      end
   endtask

   initial begin
      test_reset();
      test_div();
      test_div_zero();
      test_mul();
      test_annul();
      test_start_ignored();
      test_idle_annul();
      test_back_to_back();
      test_step2();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide engine for the EX stage, producing the 2×WIDTH HI/LO result pair for MULT/MULTU/DIV/DIVU. It replaces the ALU-embedded divider control with a self-contained start/done handshake, operand capture, annul support and configurable width and radix. The ALU holds the pipeline stall while `busy` is high and writes HI/LO on `done`.

## Interface
- `WIDTH`, 32: operand width; even, ≥ 8.
- `STEP`, 1: quotient/multiplier bits retired per cycle; 1 or 2; must divide `WIDTH`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request; accepted only in IDLE.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `a` in WIDTH: multiplicand/dividend; sampled with `start`.
- `b` in WIDTH: multiplier/divisor; sampled with `start`.
- `annul` in 1: abort the operation in flight (exception flush).
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; `hi`/`lo` valid.
- `hi` out WIDTH: remainder (div) or upper product half (mul).
- `lo` out WIDTH: quotient (div) or lower product half (mul).
- `div_zero` out 1: last completed divide had `b == 0`; held with `hi`/`lo`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start & ~annul` captures `op`, `a`, `b`, then goes to RUN (or DONE directly for a fast multiply, see Configuration). Otherwise stays in IDLE.
- Capture: operands are latched once. Later changes on `a`/`b`/`op` have no effect until the next accepted start.
- Signed ops work on magnitudes and fix signs at the end:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide uses restoring shift-subtract, STEP bits per cycle. Partial remainder is WIDTH+1 bits.
- Multiply uses shift-add, STEP bits per cycle, with a 2×WIDTH accumulator.
- Divide by zero runs the normal latency, then gives `lo` = all ones, `hi` = `a`, `div_zero` = 1.
- Signed MIN / −1 gives `lo` = MIN, `hi` = 0, `div_zero` = 0.
- DONE: lasts one cycle, drives `done` = 1 and updates `hi`/`lo`/`div_zero`, then returns to IDLE.
- `hi`/`lo`/`div_zero` hold their values until the next DONE.
- `annul` in RUN: returns to IDLE at the next edge. No `done`; `hi`/`lo`/`div_zero` unchanged.
- `annul` in IDLE: any simultaneous `start` is ignored.
- `annul` in DONE: the result still commits. The pipeline discards it.
- `start` in RUN or DONE is ignored. It is not queued.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, `div_zero` 0, counter 0.
- Accept at edge k: `busy` = 1 from cycle k+1 through the DONE cycle inclusive.
- RUN lasts WIDTH/STEP cycles, so `done` is asserted in cycle k+WIDTH/STEP+1.
- Example: WIDTH 32, STEP 1 gives 33 cycles start-to-done.
- `done` and the new `hi`/`lo` values appear in the same cycle.
- Back-to-back: the earliest next accept is the cycle after DONE (`busy` = 0).
- `rst` mid-RUN aborts like `annul` and also clears the outputs.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle registered array product: accept → DONE next cycle, `done` at k+1.
  - Divide is unchanged.
- `MULDIV_FAST_MUL_EN` undefined:
  - Multiply uses the iterative path with the same latency as divide.
  - No WIDTH×WIDTH multiplier is inferred.

## Structure
- Shared package `muldiv_pkg` holds:
  - the `op` encodings (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`);
  - the state enum `md_state_t`;
  - the DONE-cycle constant function `md_latency(WIDTH, STEP)`.
- One sub-module, `muldiv_step`: one combinational iteration (STEP bits of subtract-or-add and shift). It is instantiated once; the FSM, counter and sign fix-up live in `muldiv_unit`.

## Test plan
All with WIDTH 32.
- DIVU `a` = 100, `b` = 7 → `done` at k+33; `lo` = 14, `hi` = 2, `div_zero` = 0, `busy` high cycles k+1..k+33.
- DIV `a` = −7 (0xFFFFFFF9), `b` = 2 → `lo` = 0xFFFFFFFD (−3), `hi` = 0xFFFFFFFF (−1); DIV `a` = 0x80000000, `b` = −1 → `lo` = 0x80000000, `hi` = 0.
- DIVU `b` = 0, `a` = 0x1234 → `lo` = 0xFFFFFFFF, `hi` = 0x1234, `div_zero` = 1; `done` at normal latency.
- MULT `a` = −3, `b` = 5 → {`hi`,`lo`} = 0xFFFFFFFF_FFFFFFF1; MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 1. Run both with and without `MULDIV_FAST_MUL_EN`; check `done` at k+1 vs k+33.
- Annul and restart sequence:
  - `annul` at RUN cycle 10 → IDLE, no `done`, prior `hi`/`lo` retained.
  - New DIVU 9/3 accepted next cycle → `lo` = 3, `hi` = 0.
  - `start` pulsed mid-RUN → ignored.
- STEP = 2 → DIVU 100/7 `done` at k+17 with the same results; `rst` mid-RUN clears all outputs and `busy`.
